// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator: pixel coordinates,
// display enable, sync pins and frame-level strobes.
interface vga_timing_gen_if #(
  parameter int FRAME_W = 8
);
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               blank;
  logic               hsync;
  logic               vsync;
  logic               frame_start;
  logic               vblank_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hsync, vsync, frame_start, vblank_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hsync, vsync, frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running 640x480 raster timing generator: h/v counters plus one
// registered decode stage so every output describes the same pixel.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int FRAME_W   = 8
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  // Both totals must fit the fixed 10-bit coordinate width (<= 1024).
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0]         h_cnt_q, h_cnt_d;
  logic [9:0]         v_cnt_q, v_cnt_d;
  logic [9:0]         draw_x_q, draw_x_d;
  logic [9:0]         draw_y_q, draw_y_d;
  logic               blank_q, blank_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               frame_start_q, frame_start_d;
  logic               vblank_start_q, vblank_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               started_q, started_d;
  logic               at_origin;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through this block can leave a value held, which would infer a latch.
    h_cnt_d        = h_cnt_q + 10'd1;
    v_cnt_d        = v_cnt_q;
    at_origin      = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    draw_x_d       = h_cnt_q;
    draw_y_d       = v_cnt_q;
    blank_d        = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hsync_d        = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vsync_d        = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    frame_start_d  = at_origin;
    vblank_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS);
    frame_count_d  = frame_count_q;
    started_d      = 1'b1;

    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end

    // The very first (0,0) after reset belongs to frame 0; later ones count.
    if (at_origin && started_q) begin
      frame_count_d = frame_count_q + FRAME_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample the previous cycle's values regardless of statement order.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      draw_x_q       <= '0;
      draw_y_q       <= '0;
      blank_q        <= 1'b0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= '0;
      started_q      <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      draw_x_q       <= draw_x_d;
      draw_y_q       <= draw_y_d;
      blank_q        <= blank_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
      started_q      <= started_d;
    end
  end

  assign vga.DrawX        = draw_x_q;
  assign vga.DrawY        = draw_y_q;
  assign vga.blank        = blank_q;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;
  assign vga.frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked every cycle against
// a raster-position model, with randomized asynchronous reset pulses.
module tb_vga_timing_gen;

  typedef struct {
    int x;
    int y;
    int blank;
    int hs;
    int vs;
    int fs;
    int vbs;
    int fc;
  } outs_t;

  logic clk = 1'b0;
  logic rst_big_n = 1'b0;
  logic rst_mid_n = 1'b0;
  logic rst_sml_n = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.FRAME_W(8)) big_if ();
  vga_timing_gen_if #(.FRAME_W(8)) mid_if ();
  vga_timing_gen_if #(.FRAME_W(2)) sml_if ();

  vga_timing_gen u_big (
    .vga_clk (clk),
    .reset_n (rst_big_n),
    .vga     (big_if)
  );

  vga_timing_gen #(
    .H_VISIBLE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VISIBLE(48), .V_FP(3), .V_SYNC(2), .V_BP(4), .FRAME_W(8)
  ) u_mid (
    .vga_clk (clk),
    .reset_n (rst_mid_n),
    .vga     (mid_if)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_VISIBLE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .FRAME_W(2)
  ) u_sml (
    .vga_clk (clk),
    .reset_n (rst_sml_n),
    .vga     (sml_if)
  );

  // Expected outputs after k clock edges since reset release (k=0: in reset).
  function automatic outs_t model(input int hv, input int hf, input int hsw, input int hb,
                                  input int vv, input int vf, input int vsw, input int vb,
                                  input int fw, input int k);
    outs_t o;
    int ht, vt, per, pos;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    per = ht * vt;
    if (k == 0) begin
      o.x = 0; o.y = 0; o.blank = 0; o.hs = 1; o.vs = 1; o.fs = 0; o.vbs = 0; o.fc = 0;
      return o;
    end
    pos     = (k - 1) % per;
    o.x     = pos % ht;
    o.y     = pos / ht;
    o.blank = (o.x < hv && o.y < vv) ? 1 : 0;
    o.hs    = (o.x >= hv + hf && o.x < hv + hf + hsw) ? 0 : 1;
    o.vs    = (o.y >= vv + vf && o.y < vv + vf + vsw) ? 0 : 1;
    o.fs    = (pos == 0) ? 1 : 0;
    o.vbs   = (o.x == 0 && o.y == vv) ? 1 : 0;
    o.fc    = ((k - 1) / per) % (1 << fw);
    return o;
  endfunction

  function automatic outs_t exp_big(input int k);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 8, k);
  endfunction
  function automatic outs_t exp_mid(input int k);
    return model(64, 4, 8, 4, 48, 3, 2, 4, 8, k);
  endfunction
  function automatic outs_t exp_sml(input int k);
    return model(4, 1, 1, 1, 2, 1, 1, 1, 2, k);
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp(input string tag, input outs_t a, input outs_t e);
    check({tag, ".DrawX"}, a.x, e.x);
    check({tag, ".DrawY"}, a.y, e.y);
    check({tag, ".blank"}, a.blank, e.blank);
    check({tag, ".hsync"}, a.hs, e.hs);
    check({tag, ".vsync"}, a.vs, e.vs);
    check({tag, ".frame_start"}, a.fs, e.fs);
    check({tag, ".vblank_start"}, a.vbs, e.vbs);
    check({tag, ".frame_count"}, a.fc, e.fc);
  endtask

  outs_t act_big, act_mid, act_sml;

  always @* begin
    act_big = '{x: int'(big_if.DrawX), y: int'(big_if.DrawY), blank: int'(big_if.blank),
                hs: int'(big_if.hsync), vs: int'(big_if.vsync), fs: int'(big_if.frame_start),
                vbs: int'(big_if.vblank_start), fc: int'(big_if.frame_count)};
    act_mid = '{x: int'(mid_if.DrawX), y: int'(mid_if.DrawY), blank: int'(mid_if.blank),
                hs: int'(mid_if.hsync), vs: int'(mid_if.vsync), fs: int'(mid_if.frame_start),
                vbs: int'(mid_if.vblank_start), fc: int'(mid_if.frame_count)};
    act_sml = '{x: int'(sml_if.DrawX), y: int'(sml_if.DrawY), blank: int'(sml_if.blank),
                hs: int'(sml_if.hsync), vs: int'(sml_if.vsync), fs: int'(sml_if.frame_start),
                vbs: int'(sml_if.vblank_start), fc: int'(sml_if.frame_count)};
  end

  // Edges since each reset release; zeroed asynchronously by that reset.
  int e_big = 0, e_mid = 0, e_sml = 0;
  always @(posedge clk or negedge rst_big_n) e_big <= rst_big_n ? e_big + 1 : 0;
  always @(posedge clk or negedge rst_mid_n) e_mid <= rst_mid_n ? e_mid + 1 : 0;
  always @(posedge clk or negedge rst_sml_n) e_sml <= rst_sml_n ? e_sml + 1 : 0;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    cmp("big", act_big, exp_big(e_big));
    cmp("mid", act_mid, exp_mid(e_mid));
    cmp("sml", act_sml, exp_sml(e_sml));
  end

  // Hand-computed pins of the 640x480 line-0 timing.
  always @(negedge clk) begin
    if (rst_big_n) begin
      case (e_big)
        1: begin
          check("big_e1_x", act_big.x, 0);
          check("big_e1_y", act_big.y, 0);
          check("big_e1_blank", act_big.blank, 1);
          check("big_e1_fs", act_big.fs, 1);
        end
        640: check("big_blank_x639", act_big.blank, 1);
        641: check("big_blank_x640", act_big.blank, 0);
        656: check("big_hs_x655", act_big.hs, 1);
        657: check("big_hs_x656", act_big.hs, 0);
        752: check("big_hs_x751", act_big.hs, 0);
        753: check("big_hs_x752", act_big.hs, 1);
        800: begin
          check("big_x799", act_big.x, 799);
          check("big_y_line0", act_big.y, 0);
        end
        801: begin
          check("big_wrap_x", act_big.x, 0);
          check("big_wrap_y", act_big.y, 1);
        end
        default: ;
      endcase
    end
  end

  // Frame-level properties of the mid-size raster (80x57, 64x48 visible).
  int mid_nfs = 0, mid_last = 0, mid_vs_low = 0, mid_vbs = 0, mid_vis = 0;
  always @(negedge clk) begin
    if (!rst_mid_n || e_mid == 0) begin
      mid_nfs = 0; mid_vs_low = 0; mid_vbs = 0; mid_vis = 0;
    end else begin
      if (mid_if.frame_start) begin
        if (mid_nfs > 0) begin
          check("mid_period", e_mid - mid_last, 4560);
          check("mid_vsync_low_cycles", mid_vs_low, 160);
          check("mid_vblank_pulses", mid_vbs, 1);
          check("mid_visible_cycles", mid_vis, 3072);
        end
        check("mid_frame_count_step", act_mid.fc, mid_nfs);
        mid_last = e_mid; mid_nfs++;
        mid_vs_low = 0; mid_vbs = 0; mid_vis = 0;
      end
      if (!mid_if.vsync) mid_vs_low++;
      if (mid_if.vblank_start) mid_vbs++;
      if (mid_if.blank) mid_vis++;
      if (act_mid.y >= 48) check("mid_blank_in_vblank", act_mid.blank, 0);
    end
  end

  // Small raster: 35-cycle frames and a 2-bit frame_count that wraps.
  int sml_fc_seq [5] = '{0, 1, 2, 3, 0};
  int sml_nfs = 0, sml_last = 0;
  always @(negedge clk) begin
    if (!rst_sml_n || e_sml == 0) begin
      sml_nfs = 0;
    end else if (sml_if.frame_start) begin
      if (sml_nfs > 0) check("sml_period", e_sml - sml_last, 35);
      if (sml_nfs < 5) check("sml_frame_count_seq", act_sml.fc, sml_fc_seq[sml_nfs]);
      sml_last = e_sml; sml_nfs++;
    end
  end

  initial begin
    bit got;
    repeat (5) @(posedge clk);
    #1;
    cmp("big_in_reset", act_big, exp_big(0));
    rst_big_n = 1'b1;
    rst_mid_n = 1'b1;
    rst_sml_n = 1'b1;

    // Big raster: short reset pulse while showing (300,2).
    repeat (1901) @(posedge clk);
    #1;
    check("big_pre_rst_x", act_big.x, 300);
    check("big_pre_rst_y", act_big.y, 2);
    rst_big_n = 1'b0;
    #1;
    cmp("big_async_rst", act_big, exp_big(0));
    #1;
    rst_big_n = 1'b1;
    @(posedge clk);
    #1;
    check("big_restart_x", act_big.x, 0);
    check("big_restart_y", act_big.y, 0);
    check("big_restart_fc", act_big.fc, 0);

    // Let the mid raster run past three full frames.
    repeat (12000) @(posedge clk);

    // Mid raster: reset pulse at (30,20) of a frame.
    got = 1'b0;
    for (int i = 0; i < 10000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (mid_if.frame_start) got = 1'b1;
    end
    if (!got) check("mid_frame_start_wait", 0, 1);
    repeat (1630) @(posedge clk);
    #1;
    check("mid_pre_rst_x", act_mid.x, 30);
    check("mid_pre_rst_y", act_mid.y, 20);
    rst_mid_n = 1'b0;
    #1;
    cmp("mid_async_rst", act_mid, exp_mid(0));
    #1;
    rst_mid_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_restart_fs", act_mid.fs, 1);
    check("mid_restart_fc", act_mid.fc, 0);

    // Small raster: randomly placed sub-cycle reset pulses.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 150)) @(posedge clk);
      #($urandom_range(1, 2));
      rst_sml_n = 1'b0;
      #1;
      cmp("sml_async_rst", act_sml, exp_sml(0));
      #1;
      rst_sml_n = 1'b1;
    end

    repeat (300) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
